// File: rtl/control_seq_pkg.sv
// control_seq_pkg: shared state encoding and step-index width helper for the T-state sequencer.
package control_seq_pkg;
    typedef enum logic {ST_RUN, ST_HALTED} state_e;
    function automatic int step_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/control_seq_step_decoder.sv
// step_decoder: binary step index to one-hot T-state lines, all low when disabled.
module step_decoder #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [W-1:0] step_i,
    input  logic         en_i,
    output logic [N-1:0] s_o
);
    always_comb s_o = en_i ? ({{(N-1){1'b0}}, 1'b1} << step_i) : '0;
endmodule

// File: rtl/control_seq.sv
// control_seq: parametrised T-state ring with early end, stall, sticky halt and retired count.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int NUM_STEPS = 6,
    parameter int MIN_STEP  = 3,
    parameter int CNT_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clr_i,
    input  logic                           en_i,
    input  logic                           end_cycle_i,
    input  logic                           halt_i,
    output logic [NUM_STEPS-1:0]           s_o,
    output logic [step_w(NUM_STEPS)-1:0]   step_o,
    output logic                           cycle_done_o,
    output logic                           halted_o,
    output logic [CNT_W-1:0]               instr_cnt_o
);
    localparam int SW = step_w(NUM_STEPS);

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run, wrap;

    always_comb begin
        run          = state_q == ST_RUN;
        wrap         = (step_q == SW'(NUM_STEPS - 1)) || (end_cycle_i && step_q >= SW'(MIN_STEP));
        cycle_done_o = run && en_i && !halt_i && !clr_i && wrap;
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        if (clr_i) begin
            state_d = ST_RUN;
            step_d  = '0;
            cnt_d   = '0;
        end else if (run && halt_i) begin
            state_d = ST_HALTED;
            step_d  = '0;
        end else if (run && en_i) begin
            step_d = cycle_done_o ? '0 : step_q + 1'b1;
            cnt_d  = cnt_q + CNT_W'(cycle_done_o);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    step_decoder #(.N(NUM_STEPS), .W(SW)) u_dec (
        .step_i (step_q),
        .en_i   (run),
        .s_o    (s_o)
    );

    assign step_o      = step_q;
    assign halted_o    = state_q == ST_HALTED;
    assign instr_cnt_o = cnt_q;
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: default and minimal (2-step, 2-bit count) sequencers against a behavioural model.
module tb_control_seq;
    logic clk = 0, rst, clr, en, endc, halt;
    logic [5:0] s_a;
    logic [2:0] step_a;
    logic [7:0] cnt_a;
    logic       cd_a, hl_a;
    logic [1:0] s_b;
    logic [0:0] step_b;
    logic [1:0] cnt_b;
    logic       cd_b, hl_b;
    int total = 0, bad = 0;
    bit chk_on = 0;
    int nst[2] = '{6, 2};
    int mst[2] = '{3, 1};
    int cw[2]  = '{8, 2};
    int mstep[2] = '{0, 0};
    int mhalt[2] = '{0, 0};
    int mcnt[2]  = '{0, 0};

    always #50 clk = ~clk;

    control_seq u_a (
        .clk_i(clk), .reset_i(rst), .clr_i(clr), .en_i(en), .end_cycle_i(endc), .halt_i(halt),
        .s_o(s_a), .step_o(step_a), .cycle_done_o(cd_a), .halted_o(hl_a), .instr_cnt_o(cnt_a)
    );
    control_seq #(.NUM_STEPS(2), .MIN_STEP(1), .CNT_W(2)) u_b (
        .clk_i(clk), .reset_i(rst), .clr_i(clr), .en_i(en), .end_cycle_i(endc), .halt_i(halt),
        .s_o(s_b), .step_o(step_b), .cycle_done_o(cd_b), .halted_o(hl_b), .instr_cnt_o(cnt_b)
    );

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // An instruction ends at the last step, or early once past the uncuttable fetch steps.
    function automatic bit ends(input int i);
        return mstep[i] == nst[i] - 1 || (endc && mstep[i] >= mst[i]);
    endfunction

    function automatic bit exp_done(input int i);
        return !mhalt[i] && en && !halt && !clr && ends(i);
    endfunction

    function automatic int exp_s(input int i);
        return mhalt[i] != 0 ? 0 : (1 << mstep[i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || clr) begin
                mstep[i] <= 0;
                mhalt[i] <= 0;
                mcnt[i]  <= 0;
            end else if (mhalt[i] == 0) begin
                if (halt) begin
                    mhalt[i] <= 1;
                    mstep[i] <= 0;
                end else if (en) begin
                    if (ends(i)) begin
                        mstep[i] <= 0;
                        mcnt[i]  <= (mcnt[i] + 1) % (1 << cw[i]);
                    end else begin
                        mstep[i] <= mstep[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a.s", s_a, exp_s(0));
            cmp("a.step", step_a, mstep[0]);
            cmp("a.done", cd_a, exp_done(0));
            cmp("a.halted", hl_a, mhalt[0]);
            cmp("a.cnt", cnt_a, mcnt[0]);
            cmp("b.s", s_b, exp_s(1));
            cmp("b.step", step_b, mstep[1]);
            cmp("b.done", cd_b, exp_done(1));
            cmp("b.halted", hl_b, mhalt[1]);
            cmp("b.cnt", cnt_b, mcnt[1]);
        end
    end

    task automatic drive(input logic e, input logic ec, input logic h, input logic c);
        @(posedge clk);
        #1;
        en = e; endc = ec; halt = h; clr = c;
        @(negedge clk);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #20 rst = 1;
        #1;
        cmp("ar.s_a", s_a, 1);
        cmp("ar.cnt_a", cnt_a, 0);
        cmp("ar.halted_a", hl_a, 0);
        cmp("ar.s_b", s_b, 1);
        cmp("ar.cnt_b", cnt_b, 0);
        #10 rst = 0;
    endtask

    initial begin
        rst = 0; en = 1; endc = 0; halt = 0; clr = 0;
        #5 rst = 1;
        chk_on = 1;
        @(negedge clk);
        cmp("rst.s", s_a, 6'b000001);
        @(negedge clk);
        cmp("rst.s2", s_a, 6'b000001);
        cmp("rst.cnt", cnt_a, 0);
        @(posedge clk);
        #1 rst = 0;
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 0, 0);
            cmp("walk.s", s_a, 1 << k);
            cmp("walk.done", cd_a, k == 5);
            if (k == 1) begin
                cmp("b.walk.s", s_b, 2'b10);
                cmp("b.walk.done", cd_b, 1);
            end
        end
        drive(1, 0, 0, 0);
        cmp("wrap.s", s_a, 6'b000001);
        cmp("wrap.cnt", cnt_a, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        cmp("early.at3", s_a, 6'b001000);
        cmp("early.done", cd_a, 1);
        drive(1, 0, 0, 0);
        cmp("early.s", s_a, 6'b000001);
        cmp("early.cnt", cnt_a, 2);
        drive(1, 1, 0, 0);
        cmp("fetch.done", cd_a, 0);
        drive(0, 0, 0, 0);
        cmp("fetch.s", s_a, 6'b000100);
        cmp("stall.done", cd_a, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        cmp("stall.s", s_a, 6'b000100);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        cmp("resume.s", s_a, 6'b001000);
        drive(1, 1, 1, 0);
        cmp("halt.at4", s_a, 6'b010000);
        cmp("halt.done", cd_a, 0);
        drive(0, 1, 0, 0);
        cmp("halt.s", s_a, 0);
        cmp("halt.flag", hl_a, 1);
        cmp("halt.cnt", cnt_a, 2);
        drive(1, 1, 0, 0);
        drive(1, 0, 1, 1);
        cmp("halt.sticky", hl_a, 1);
        drive(1, 0, 0, 0);
        cmp("clr.s", s_a, 6'b000001);
        cmp("clr.halted", hl_a, 0);
        cmp("clr.cnt", cnt_a, 0);
        for (int k = 0; k < 10; k++) drive(1, 0, 0, 0);
        cmp("run10.s_a", s_a, 6'b010000);
        cmp("run10.cnt_a", cnt_a, 1);
        cmp("run10.cnt_b", cnt_b, 1);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
